radar_cpi_sequencer: RTL and testbench

- Sequences one coherent processing interval (CPI) of PRF_N pulses for the IF-LFM receive chain: echo/DAC playback, DDC → pulse compression → MTI.
- Produces the transmit window, the receive range gate, range-bin and pulse indices, and the MTI framing strobes (start_flag, rec_flag).
- Sits beside the DDC/PC/MTI datapath in the receiver top, clocked in the sample domain.

---
 rtl/radar_cpi_sequencer_if.sv | 31 +++
 rtl/radar_cpi_sequencer.sv | 167 ++++++++++++++++
 tb/tb_radar_cpi_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/radar_cpi_sequencer_if.sv
// Control/status bundle between the CPI sequencer and its controller.
// The controller drives start/stop/continuous; the sequencer drives timing.
interface radar_cpi_sequencer_if #(
  parameter int CNT_W  = 12,
  parameter int PIDX_W = 4
);
  logic              start;
  logic              stop;
  logic              continuous;
  logic              busy;
  logic              tx_en;
  logic              pulse_start;
  logic              rx_gate;
  logic [CNT_W-1:0]  range_bin;
  logic [PIDX_W-1:0] pulse_idx;
  logic              start_flag;
  logic              rec_flag;
  logic              cpi_done;

  modport master (
    output start, stop, continuous,
    input  busy, tx_en, pulse_start, rx_gate, range_bin, pulse_idx,
           start_flag, rec_flag, cpi_done
  );

  modport slave (
    input  start, stop, continuous,
    output busy, tx_en, pulse_start, rx_gate, range_bin, pulse_idx,
           start_flag, rec_flag, cpi_done
  );
endinterface

// File: rtl/radar_cpi_sequencer.sv
// CPI sequencer: walks PRF_N pulse repetition intervals and produces the
// transmit window, range gate, range/pulse indices and MTI framing strobes.
// Control inputs are registered once; every FSM decision uses that registered
// view, so a start seen on edge N enters RUN on edge N+1.
// All outputs are the registered image of the count the FSM moves to.
module radar_cpi_sequencer #(
  parameter int PRF_N        = 16,
  parameter int PRI_CYCLES   = 1024,
  parameter int PULSE_CYCLES = 256,
  parameter int RX_DELAY     = 256,
  parameter int GATE_LEN     = 512,
  parameter int CNT_W        = 12,
  parameter int PIDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  radar_cpi_sequencer_if.slave   bus
);

  // Illegal configurations are rejected at elaboration.
  if (PRF_N < 2) begin : g_chk_prf
    $error("PRF_N must be at least 2");
  end
  if (RX_DELAY < PULSE_CYCLES) begin : g_chk_rxd
    $error("RX_DELAY must be >= PULSE_CYCLES");
  end
  if (RX_DELAY + GATE_LEN > PRI_CYCLES) begin : g_chk_gate
    $error("RX_DELAY + GATE_LEN must fit inside PRI_CYCLES");
  end
  if (PRI_CYCLES > (1 << CNT_W)) begin : g_chk_cntw
    $error("CNT_W too narrow for PRI_CYCLES");
  end
  if ((1 << PIDX_W) < PRF_N) begin : g_chk_pidxw
    $error("PIDX_W too narrow for PRF_N");
  end
  if (PULSE_CYCLES < 1 || GATE_LEN < 1) begin : g_chk_len
    $error("PULSE_CYCLES and GATE_LEN must be positive");
  end

  localparam logic [CNT_W-1:0]  PRI_LAST   = CNT_W'(PRI_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TX_END     = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0]  GATE_FIRST = CNT_W'(RX_DELAY);
  localparam logic [CNT_W-1:0]  GATE_LAST  = CNT_W'(RX_DELAY + GATE_LEN - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST  = PIDX_W'(PRF_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  pri_cnt, nxt_cnt;
  logic [PIDX_W-1:0] pidx, nxt_pidx;
  logic              stop_lat, nxt_lat;
  logic              start_q, stop_q, cont_q;
  logic              stop_any;

  logic              busy_r, tx_en_r, pulse_start_r, rx_gate_r;
  logic [CNT_W-1:0]  range_bin_r;
  logic [PIDX_W-1:0] pulse_idx_r;
  logic              start_flag_r, rec_flag_r, cpi_done_r;

  // Image of the next count, used to build the registered outputs.
  logic              nxt_run, nxt_gated;

  assign stop_any  = stop_lat | stop_q;
  assign nxt_run   = (nxt_state == RUN);
  assign nxt_gated = nxt_run && (nxt_cnt >= GATE_FIRST) && (nxt_cnt <= GATE_LAST);

  // Next-state decode: PRI counting, pulse stepping, stop handling at PRI boundary.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = pri_cnt;
    nxt_pidx  = pidx;
    nxt_lat   = stop_lat;
    case (state)
      IDLE: begin
        nxt_lat = 1'b0;
        if (start_q && !stop_q) begin
          nxt_state = RUN;
          nxt_cnt   = '0;
          nxt_pidx  = '0;
        end
      end
      RUN: begin
        nxt_lat = stop_any;
        if (pri_cnt == PRI_LAST) begin
          nxt_cnt = '0;
          if (stop_any) begin
            // Aborted CPI: no cpi_done, indices clear.
            nxt_state = IDLE;
            nxt_pidx  = '0;
            nxt_lat   = 1'b0;
          end else if (pidx == PIDX_LAST) begin
            nxt_state = DONE;
            nxt_pidx  = '0;
          end else begin
            nxt_pidx = pidx + 1'b1;
          end
        end else begin
          nxt_cnt = pri_cnt + 1'b1;
        end
      end
      DONE: begin
        nxt_lat  = 1'b0;
        nxt_cnt  = '0;
        nxt_pidx = '0;
        // Back-to-back CPIs leave exactly one DONE clock between them.
        nxt_state = (cont_q && !stop_q) ? RUN : IDLE;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_pidx  = '0;
        nxt_lat   = 1'b0;
      end
    endcase
  end

  // FSM state, input sampling and registered timing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pri_cnt       <= '0;
      pidx          <= '0;
      stop_lat      <= 1'b0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      cont_q        <= 1'b0;
      busy_r        <= 1'b0;
      tx_en_r       <= 1'b0;
      pulse_start_r <= 1'b0;
      rx_gate_r     <= 1'b0;
      range_bin_r   <= '0;
      pulse_idx_r   <= '0;
      start_flag_r  <= 1'b0;
      rec_flag_r    <= 1'b0;
      cpi_done_r    <= 1'b0;
    end else begin
      // start is only armed while idle, so a start during RUN/DONE is dropped.
      start_q       <= bus.start && (state == IDLE);
      stop_q        <= bus.stop;
      cont_q        <= bus.continuous;
      state         <= nxt_state;
      pri_cnt       <= nxt_cnt;
      pidx          <= nxt_pidx;
      stop_lat      <= nxt_lat;
      busy_r        <= nxt_run;
      tx_en_r       <= nxt_run && (nxt_cnt < TX_END);
      pulse_start_r <= nxt_run && (nxt_cnt == '0);
      start_flag_r  <= nxt_run && (nxt_cnt == '0) && (nxt_pidx == '0);
      rx_gate_r     <= nxt_gated;
      range_bin_r   <= nxt_gated ? (nxt_cnt - GATE_FIRST) : '0;
      rec_flag_r    <= nxt_run && (nxt_cnt == GATE_LAST);
      pulse_idx_r   <= nxt_run ? nxt_pidx : '0;
      cpi_done_r    <= (nxt_state == DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.tx_en       = tx_en_r;
  assign bus.pulse_start = pulse_start_r;
  assign bus.rx_gate     = rx_gate_r;
  assign bus.range_bin   = range_bin_r;
  assign bus.pulse_idx   = pulse_idx_r;
  assign bus.start_flag  = start_flag_r;
  assign bus.rec_flag    = rec_flag_r;
  assign bus.cpi_done    = cpi_done_r;

endmodule

// File: tb/tb_radar_cpi_sequencer.sv
// Bench for radar_cpi_sequencer: a first-PRI vector table, directed CPI
// sequences and a randomized phase, all checked every cycle against a
// time-within-CPI reference model.
module tb_radar_cpi_sequencer;
  localparam int PRF_N = 16, PRI = 1024, PULSE = 256, RXD = 256, GL = 512;
  localparam int CNT_W = 12, PIDX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  radar_cpi_sequencer_if #(.CNT_W(CNT_W), .PIDX_W(PIDX_W)) bus();

  radar_cpi_sequencer #(
    .PRF_N(PRF_N), .PRI_CYCLES(PRI), .PULSE_CYCLES(PULSE), .RX_DELAY(RXD),
    .GATE_LEN(GL), .CNT_W(CNT_W), .PIDX_W(PIDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int shown    = 0;
  int cyc      = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: mode 0 idle, 1 running, 2 done; m_t is time inside CPI.
  // Control inputs act one clock after they are sampled.
  int m_mode = 0;
  int m_t    = 0;
  bit m_lat, m_sq, m_pq, m_cq, s_prev, p_prev, c_prev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_t = 0; m_lat = 0; m_sq = 0; m_pq = 0; m_cq = 0;
    end else begin
      s_prev = m_sq; p_prev = m_pq; c_prev = m_cq;
      m_sq = bus.start && (m_mode == 0);
      m_pq = bus.stop;
      m_cq = bus.continuous;
      case (m_mode)
        0: if (s_prev && !p_prev) begin m_mode = 1; m_t = 0; end
        1: begin
          m_lat = m_lat | p_prev;
          if (m_t % PRI == PRI - 1) begin
            if (m_lat) begin m_mode = 0; m_lat = 0; m_t = 0; end
            else if (m_t == PRF_N * PRI - 1) m_mode = 2;
            else m_t++;
          end else m_t++;
        end
        default: begin
          m_lat = 0;
          if (c_prev && !p_prev) begin m_mode = 1; m_t = 0; end
          else m_mode = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  logic [CNT_W+PIDX_W+7:0] act_v, exp_v;
  always @(negedge clk) begin
    if (rst) begin
      int c, p;
      logic g;
      c = m_t % PRI;
      p = m_t / PRI;
      g = (m_mode == 1) && c >= RXD && c < RXD + GL;
      exp_v = {(m_mode == 1), (m_mode == 1) && c < PULSE, (m_mode == 1) && c == 0, g,
               g ? CNT_W'(c - RXD) : CNT_W'(0), (m_mode == 1) ? PIDX_W'(p) : PIDX_W'(0),
               (m_mode == 1) && c == 0 && p == 0, (m_mode == 1) && c == RXD + GL - 1,
               (m_mode == 2)};
      act_v = {bus.busy, bus.tx_en, bus.pulse_start, bus.rx_gate, bus.range_bin,
               bus.pulse_idx, bus.start_flag, bus.rec_flag, bus.cpi_done};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        if (shown < 20) begin
          shown++;
          $display("FAIL model_cycle%0d actual=%h expected=%h", cyc, act_v, exp_v);
        end
      end
    end
  end

  // Event timestamps for interval checks.
  int ps_t[$], sf_t[$], done_t[$], rec_t[$];
  always @(negedge clk) begin
    if (rst) begin
      if (bus.pulse_start) ps_t.push_back(cyc);
      if (bus.start_flag)  sf_t.push_back(cyc);
      if (bus.cpi_done)    done_t.push_back(cyc);
      if (bus.rec_flag)    rec_t.push_back(cyc);
    end
  end

  task automatic clear_events();
    ps_t.delete(); sf_t.delete(); done_t.delete(); rec_t.delete();
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
  endtask

  task automatic wait_idle(int budget, string name);
    int n = 0;
    while (bus.busy && n < budget) begin tick(1); n++; end
    check(name, 32'(n < budget), 1);
  endtask

  task automatic wait_pulse(int idx, int budget, string name);
    int n = 0;
    while (!(bus.pulse_start === 1'b1 && bus.pulse_idx == PIDX_W'(idx)) && n < budget) begin
      tick(1); n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  typedef struct {
    int   cnt;
    logic tx, ps, sf, rx, rec;
    int   rb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int t0, n;
    tbl[0] = '{0,    1, 1, 1, 0, 0, 0};
    tbl[1] = '{1,    1, 0, 0, 0, 0, 0};
    tbl[2] = '{255,  1, 0, 0, 0, 0, 0};
    tbl[3] = '{256,  0, 0, 0, 1, 0, 0};
    tbl[4] = '{257,  0, 0, 0, 1, 0, 1};
    tbl[5] = '{511,  0, 0, 0, 1, 0, 255};
    tbl[6] = '{766,  0, 0, 0, 1, 0, 510};
    tbl[7] = '{767,  0, 0, 0, 1, 1, 511};
    tbl[8] = '{768,  0, 0, 0, 0, 0, 0};
    tbl[9] = '{1023, 0, 0, 0, 0, 0, 0};

    bus.start = 0; bus.stop = 0; bus.continuous = 0;
    #22;
    check("reset_busy", bus.busy, 0);
    check("reset_tx", bus.tx_en, 0);
    check("reset_done", bus.cpi_done, 0);
    rst = 1'b1;
    tick(3);
    check("idle_no_start", bus.busy, 0);

    // First PRI against the vector table.
    clear_events();
    start_pulse();
    check("latency_not_yet", bus.pulse_start, 0);
    tick(1);
    for (int k = 0; k < PRI; k++) begin
      for (int e = 0; e < 10; e++) begin
        if (tbl[e].cnt == k) begin
          check($sformatf("tbl%0d_tx", k),  bus.tx_en,       32'(tbl[e].tx));
          check($sformatf("tbl%0d_ps", k),  bus.pulse_start, 32'(tbl[e].ps));
          check($sformatf("tbl%0d_sf", k),  bus.start_flag,  32'(tbl[e].sf));
          check($sformatf("tbl%0d_rx", k),  bus.rx_gate,     32'(tbl[e].rx));
          check($sformatf("tbl%0d_rb", k),  bus.range_bin,   32'(tbl[e].rb));
          check($sformatf("tbl%0d_rec", k), bus.rec_flag,    32'(tbl[e].rec));
        end
      end
      tick(1);
    end

    // Remainder of the single CPI.
    wait_idle(17000, "cpi_timeout");
    tick(1);
    check("cpi_pulses", ps_t.size(), PRF_N);
    check("cpi_sflags", sf_t.size(), 1);
    check("cpi_dones", done_t.size(), 1);
    if (ps_t.size() == PRF_N) begin
      for (int i = 1; i < PRF_N; i++)
        check($sformatf("pri_spacing%0d", i), ps_t[i] - ps_t[i-1], PRI);
    end
    if (done_t.size() >= 1 && ps_t.size() >= 1)
      check("cpi_done_time", done_t[0] - ps_t[0], PRF_N * PRI);
    check("after_cpi_busy", bus.busy, 0);
    check("after_cpi_done", bus.cpi_done, 0);

    // Continuous mode: back-to-back CPIs with a one-clock gap.
    clear_events();
    bus.continuous = 1'b1;
    start_pulse();
    n = 0;
    while (done_t.size() < 2 && n < 40000) begin tick(1); n++; end
    check("cont_timeout", 32'(n < 40000), 1);
    bus.continuous = 1'b0;
    stop_pulse();
    wait_idle(3000, "cont_stop_timeout");
    if (sf_t.size() >= 2) check("cont_sf_gap", sf_t[1] - sf_t[0], PRF_N * PRI + 1);
    if (done_t.size() >= 2) check("cont_done_gap", done_t[1] - done_t[0], PRF_N * PRI + 1);

    // Stop at count 100 of pulse 5.
    tick(3);
    clear_events();
    start_pulse();
    wait_pulse(5, 7000, "wait_pulse5");
    tick(100);
    stop_pulse();
    wait_idle(2000, "stop_timeout");
    t0 = cyc;
    check("stop_pulses", ps_t.size(), 6);
    check("stop_recs", rec_t.size(), 6);
    check("stop_no_done", done_t.size(), 0);
    check("stop_pidx", bus.pulse_idx, 0);
    if (ps_t.size() >= 6) check("stop_boundary", t0 - ps_t[5], PRI);
    tick(5);
    check("stop_stays_idle", bus.busy, 0);
    clear_events();
    start_pulse();
    tick(1);
    check("restart_ps", bus.pulse_start, 1);
    check("restart_sf", bus.start_flag, 1);
    check("restart_pidx", bus.pulse_idx, 0);

    // Async reset at count 400 of pulse 3.
    wait_pulse(3, 4000, "wait_pulse3");
    tick(400);
    check("pre_rst_gate", bus.rx_gate, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_gate", bus.rx_gate, 0);
    check("rst_bin", bus.range_bin, 0);
    check("rst_pidx", bus.pulse_idx, 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    check("post_rst_idle", bus.busy, 0);

    // start with stop in idle, then start mid-CPI.
    bus.start = 1'b1; bus.stop = 1'b1; tick(1); bus.start = 1'b0; bus.stop = 1'b0;
    tick(3);
    check("start_stop_idle", bus.busy, 0);
    check("start_stop_ps", bus.pulse_start, 0);
    start_pulse();
    tick(300);
    start_pulse();
    tick(900);
    stop_pulse();
    wait_idle(2000, "midstart_timeout");

    // Randomized control activity.
    for (int i = 0; i < 6000; i++) begin
      bus.start = ($urandom_range(0, 99) < 2);
      bus.stop  = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 999) == 0) bus.continuous = ~bus.continuous;
      tick(1);
    end
    bus.start = 0; bus.continuous = 0;
    stop_pulse();
    wait_idle(3000, "rand_end_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
